// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: CSR addresses, mstatus bit positions, cause codes, FSM states
// and mstatus update helpers shared by the machine-mode trap sequencer.
`default_nettype none

package trap_ctrl_pkg;

  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MTVEC   = 32'h0000_0305;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

  localparam logic [31:0] CAUSE_INT    = 32'h8000_000B;
  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_W_MEPC    = 3'd1;
  localparam state_t ST_W_MCAUSE  = 3'd2;
  localparam state_t ST_W_MSTATUS = 3'd3;
  localparam state_t ST_W_MRET    = 3'd4;
  localparam state_t ST_JUMP      = 3'd5;

  // Trap entry: stash MIE into MPIE and disable interrupts.
  function automatic logic [31:0] mstatus_trap(input logic [31:0] m);
    logic [31:0] r;
    r           = m;
    r[MPIE_BIT] = m[MIE_BIT];
    r[MIE_BIT]  = 1'b0;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE and set MPIE.
  function automatic logic [31:0] mstatus_mret(input logic [31:0] m);
    logic [31:0] r;
    r           = m;
    r[MIE_BIT]  = m[MPIE_BIT];
    r[MPIE_BIT] = 1'b1;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer (ecall/ebreak/mret/external interrupt).
// Optional vectored interrupt dispatch when TRAP_CTRL_VECTORED_EN is defined.
`default_nettype none

module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [31:0] INT_CAUSE    = CAUSE_INT,
  parameter logic [31:0] ECALL_CAUSE  = CAUSE_ECALL,
  parameter logic [31:0] EBREAK_CAUSE = CAUSE_EBREAK
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic        int_req_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        csr_we_o,
  output logic [31:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        hold_flag_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic        busy_o
);

  state_t      r_state;
  logic [31:0] r_epc;
  logic [31:0] r_cause;
  logic        r_is_int;
  logic        r_is_mret;

  logic        w_idle;
  logic        w_int_ok;
  logic        w_accept;
  logic [31:0] w_trap_base;
  logic [31:0] w_trap_target;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_int_ok = int_req_i & csr_mstatus_i[MIE_BIT];
  // Reset suppresses acceptance so nothing is stalled during reset.
  assign w_accept = ~rst & w_idle & (ecall_i | ebreak_i | mret_i | w_int_ok);

  assign w_trap_base = {csr_mtvec_i[31:2], 2'b00};

`ifdef TRAP_CTRL_VECTORED_EN
  assign w_trap_target = (r_is_int && (csr_mtvec_i[1:0] == 2'b01))
                         ? (w_trap_base + {r_cause[29:0], 2'b00})
                         : w_trap_base;
`else
  logic w_unused_direct;
  assign w_unused_direct = ^{csr_mtvec_i[1:0], r_is_int};
  assign w_trap_target   = w_trap_base;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_epc     <= 32'd0;
      r_cause   <= 32'd0;
      r_is_int  <= 1'b0;
      r_is_mret <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ecall_i) begin
            r_state   <= ST_W_MEPC;
            r_epc     <= inst_addr_i;
            r_cause   <= ECALL_CAUSE;
            r_is_int  <= 1'b0;
            r_is_mret <= 1'b0;
          end else if (ebreak_i) begin
            r_state   <= ST_W_MEPC;
            r_epc     <= inst_addr_i;
            r_cause   <= EBREAK_CAUSE;
            r_is_int  <= 1'b0;
            r_is_mret <= 1'b0;
          end else if (mret_i) begin
            r_state   <= ST_W_MRET;
            r_is_int  <= 1'b0;
            r_is_mret <= 1'b1;
          end else if (w_int_ok) begin
            r_state   <= ST_W_MEPC;
            // A taken branch in EX means execution resumes at its target.
            r_epc     <= jump_flag_i ? jump_addr_i : (inst_addr_i + 32'd4);
            r_cause   <= INT_CAUSE;
            r_is_int  <= 1'b1;
            r_is_mret <= 1'b0;
          end
        end
        ST_W_MEPC:    r_state <= ST_W_MCAUSE;
        ST_W_MCAUSE:  r_state <= ST_W_MSTATUS;
        ST_W_MSTATUS: r_state <= ST_JUMP;
        ST_W_MRET:    r_state <= ST_JUMP;
        ST_JUMP:      r_state <= ST_IDLE;
        default:      r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    csr_we_o    = 1'b0;
    csr_waddr_o = 32'd0;
    csr_wdata_o = 32'd0;
    jump_flag_o = 1'b0;
    jump_addr_o = 32'd0;
    case (r_state)
      ST_W_MEPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MEPC;
        csr_wdata_o = r_epc;
      end
      ST_W_MCAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MCAUSE;
        csr_wdata_o = r_cause;
      end
      ST_W_MSTATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = mstatus_trap(csr_mstatus_i);
      end
      ST_W_MRET: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = mstatus_mret(csr_mstatus_i);
      end
      ST_JUMP: begin
        jump_flag_o = 1'b1;
        jump_addr_o = r_is_mret ? csr_mepc_i : w_trap_target;
      end
      default: ;
    endcase
  end

  assign hold_flag_o = ~w_idle | w_accept;
  assign busy_o      = ~w_idle;

endmodule

`default_nettype wire
